seq_64_bit_subtractor: RTL and testbench

//   Multi-cycle 64-bit subtractor with borrow: diff = a - b - borrow_in.

---
 rtl/seq_64_bit_subtractor.sv | 130 +++++++++++++
 tb/tb_seq_64_bit_subtractor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_64_bit_subtractor.sv
// Multi-cycle 64-bit subtractor: diff = a - b - borrow_in, CHUNK_W bits per cycle,
// LSB chunk first, with valid/ready handshakes on both the operand and result sides.
module seq_64_bit_subtractor #(
  parameter int unsigned CHUNK_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        borrow_in_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] diff_o,
  output logic        borrow_out_o,
  output logic        overflow_o
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned N      = DATA_W / CHUNK_W;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned SUB_W  = CHUNK_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                br_q, br_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   diff_q, diff_d;
  logic                bout_q, bout_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [OFF_W-1:0]    off;
  logic [CHUNK_W-1:0]  a_chunk;
  logic [CHUNK_W-1:0]  b_chunk;
  logic [SUB_W-1:0]    sub;
  logic                last;

  // Current chunk slice; the extra MSB of sub is the chunk's borrow-out.
  assign off     = OFF_W'(int'(idx_q) * int'(CHUNK_W));
  assign a_chunk = a_q[off +: CHUNK_W];
  assign b_chunk = b_q[off +: CHUNK_W];
  assign sub     = {1'b0, a_chunk} - {1'b0, b_chunk} - SUB_W'(br_q);
  assign last    = (idx_q == IDX_W'(N - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    br_d        = br_q;
    idx_d       = idx_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = borrow_in_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[off +: CHUNK_W] = sub[CHUNK_W-1:0];
        br_d                   = sub[CHUNK_W];
        if (last) begin
          bout_d  = sub[CHUNK_W];
          // Top bit of the final chunk is diff[63].
          ovf_d   = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) & (sub[CHUNK_W-1] ^ a_q[DATA_W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      br_q        <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      br_q        <= br_d;
      idx_q       <= idx_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign diff_o       = diff_q;
  assign borrow_out_o = bout_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_seq_64_bit_subtractor.sv
// Self-checking bench for seq_64_bit_subtractor at CHUNK_W = 16, 1 and 64,
// using a full-width arithmetic reference model.
module tb_seq_64_bit_subtractor;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [63:0] diff [3];
  logic [2:0]  bout;
  logic [2:0]  ovf;

  int n_chk;
  int n_fail;

  // Instance 0: CHUNK_W=16 (N=4), instance 1: CHUNK_W=1 (N=64), instance 2: CHUNK_W=64 (N=1).
  seq_64_bit_subtractor #(.CHUNK_W(16)) u_c16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .a_i(a), .b_i(b), .borrow_in_i(bin), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .diff_o(diff[0]), .borrow_out_o(bout[0]), .overflow_o(ovf[0])
  );
  seq_64_bit_subtractor #(.CHUNK_W(1)) u_c1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .a_i(a), .b_i(b), .borrow_in_i(bin), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .diff_o(diff[1]), .borrow_out_o(bout[1]), .overflow_o(ovf[1])
  );
  seq_64_bit_subtractor #(.CHUNK_W(64)) u_c64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .a_i(a), .b_i(b), .borrow_in_i(bin), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .diff_o(diff[2]), .borrow_out_o(bout[2]), .overflow_o(ovf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on instance k; hold>0 keeps out_ready low that many cycles in DONE
  // while new operands are offered on in_valid.
  task automatic do_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                       input logic bi, input int lat, input int hold);
    logic [64:0] full;
    logic [63:0] ed;
    logic        eb;
    logic        eo;
    int          cyc;
    full = {1'b0, av} - {1'b0, bv} - 65'(bi);
    ed   = full[63:0];
    eb   = full[64];
    eo   = (av[63] != bv[63]) && (ed[63] != av[63]);
    cyc  = 0;
    while (!in_ready[k] && cyc < 10) begin
      step();
      cyc++;
    end
    chk("in_ready_idle", 64'(in_ready[k]), 64'd1);
    a = av; b = bv; bin = bi; in_valid[k] = 1'b1;
    step();
    in_valid[k] = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
    chk("in_ready_run", 64'(in_ready[k]), 64'd0);
    cyc = 0;
    while (!out_valid[k] && cyc < 200) begin
      step();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(lat));
    chk("diff", diff[k], ed);
    chk("borrow_out", 64'(bout[k]), 64'(eb));
    chk("overflow", 64'(ovf[k]), 64'(eo));
    chk("in_ready_done", 64'(in_ready[k]), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      step();
      chk("hold_out_valid", 64'(out_valid[k]), 64'd1);
      chk("hold_diff", diff[k], ed);
      chk("hold_borrow", 64'(bout[k]), 64'(eb));
      chk("hold_in_ready", 64'(in_ready[k]), 64'd0);
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
    chk("out_valid_drop", 64'(out_valid[k]), 64'd0);
    chk("diff_kept", diff[k], ed);
    chk("in_ready_back", 64'(in_ready[k]), 64'd1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    in_valid = '0;
    out_ready = '0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready[0]), 64'd0);
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_diff", diff[0], 64'd0);
    chk("rst_borrow", 64'(bout[0]), 64'd0);
    chk("rst_overflow", 64'(ovf[0]), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);

    // Directed vectors
    do_op(0, 64'd87903422, 64'd1245634, 1'b1, 4, 0);
    do_op(0, 64'd2222, 64'd9999, 1'b0, 4, 0);
    do_op(0, 64'd0, 64'd0, 1'b1, 4, 0);
    do_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 4, 0);
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4, 0);

    // Stall in DONE with new operands offered, then the new pair alone
    do_op(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 4, 10);
    do_op(0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_DEAD_BEEF, 1'b0, 4, 0);

    // Random operands, every fourth case with a == b to stress the borrow chain
    for (int i = 0; i < 20; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = (i % 4 == 0) ? ra : {$urandom, $urandom};
      do_op(0, ra, rb, 1'($urandom_range(0, 1)), 4, 0);
    end

    // Reset together with in_valid: nothing may be captured
    rst = 1'b1;
    in_valid[0] = 1'b1;
    a = 64'd55; b = 64'd11; bin = 1'b0;
    step();
    step();
    rst = 1'b0;
    in_valid[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_wins_no_result", 64'(out_valid[0]), 64'd0);
    end

    // Reset two cycles after an accept abandons the operation
    a = 64'd87903422; b = 64'd1245634; bin = 1'b1; in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_diff", diff[0], 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd0);
    step();
    chk("mid_rst_out_valid2", 64'(out_valid[0]), 64'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_in_ready_after", 64'(in_ready[0]), 64'd1);
    chk("mid_rst_no_result", 64'(out_valid[0]), 64'd0);
    do_op(0, 64'd4000, 64'd4001, 1'b0, 4, 0);

    // Same scenario at CHUNK_W = 1 and 64
    do_op(1, 64'd87903422, 64'd1245634, 1'b1, 64, 0);
    do_op(2, 64'd87903422, 64'd1245634, 1'b1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_op(1, ra, rb, 1'($urandom_range(0, 1)), 64, 0);
      do_op(2, ra, rb, 1'($urandom_range(0, 1)), 1, 0);
    end
    do_op(1, 64'd0, 64'd0, 1'b1, 64, 0);
    do_op(2, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
